// File: rtl/atom_nrnw_if.sv
// Bus bundle for the atom_nrnw multiport memory leaf: read/write request ports,
// registered read returns and the status pulses.
interface atom_nrnw_if #(
  parameter int BITADDR = 3,
  parameter int BITDATA = 8,
  parameter int NUMRDPT = 2,
  parameter int NUMWRPT = 2
);
  logic                         ready;
  logic [NUMRDPT-1:0]           read;
  logic [NUMRDPT*BITADDR-1:0]   rd_adr;
  logic [NUMRDPT-1:0]           rd_vld;
  logic [NUMRDPT*BITDATA-1:0]   rd_dout;
  logic [NUMWRPT-1:0]           write;
  logic [NUMWRPT*BITADDR-1:0]   wr_adr;
  logic [NUMWRPT*BITDATA-1:0]   wr_din;
  logic                         wr_coll;
  logic                         adr_err;

  modport master (
    input  ready, rd_vld, rd_dout, wr_coll, adr_err,
    output read, rd_adr, write, wr_adr, wr_din
  );

  modport slave (
    output ready, rd_vld, rd_dout, wr_coll, adr_err,
    input  read, rd_adr, write, wr_adr, wr_din
  );
endinterface

// File: rtl/atom_nrnw.sv
// Multiport memory atom: NUMRDPT registered read ports, NUMWRPT write ports,
// optional post-reset initialisation walk, collision and address-error pulses.
module atom_nrnw #(
  parameter int NUMADDR    = 8,
  parameter int BITADDR    = 3,
  parameter int BITDATA    = 8,
  parameter int NUMRDPT    = 2,
  parameter int NUMWRPT    = 2,
  parameter int SRAM_DELAY = 1,
  parameter int RSTINIT    = 0,
  parameter int RSTSTRT    = 0,
  parameter int RSTINCR    = 0
) (
  input logic       clk,
  input logic       rst,
  atom_nrnw_if.slave bus
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [BITADDR:0]   ADR_LIMIT = (BITADDR+1)'(NUMADDR);
  localparam logic [BITADDR-1:0] CNT_LAST  = BITADDR'(NUMADDR-1);

  state_t               state, state_nxt;
  logic [BITADDR-1:0]   cnt, cnt_nxt;
  logic [BITDATA-1:0]   init_val, init_val_nxt;
  logic                 walk_en;
  logic                 ready_r;

  logic [BITDATA-1:0]   mem [0:NUMADDR-1];

  logic [NUMRDPT-1:0]         rd_req;
  logic [NUMWRPT-1:0]         wr_req;
  logic [BITADDR-1:0]         rd_a [NUMRDPT];
  logic [BITADDR-1:0]         wr_a [NUMWRPT];
  logic [NUMRDPT*BITDATA-1:0] rd_pack;
  logic                       coll, err;

  logic [NUMRDPT-1:0]         pipe_vld [SRAM_DELAY];
  logic [NUMRDPT*BITDATA-1:0] pipe_dat [SRAM_DELAY];
  logic                       coll_r, err_r;

  function automatic logic in_range(input logic [BITADDR-1:0] a);
    return {1'b0, a} < ADR_LIMIT;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      cnt      <= '0;
      init_val <= BITDATA'(RSTSTRT);
      ready_r  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      init_val <= init_val_nxt;
      ready_r  <= (state_nxt == READY);
    end
  end

  // The walk keeps a running value instead of multiplying cnt*RSTINCR.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    init_val_nxt = init_val;
    walk_en      = 1'b0;
    if (state == INIT) begin
      if (RSTINIT == 0) begin
        state_nxt = READY;
      end else begin
        walk_en      = 1'b1;
        cnt_nxt      = cnt + 1'b1;
        init_val_nxt = init_val + BITDATA'(RSTINCR);
        if (cnt == CNT_LAST) state_nxt = READY;
      end
    end
  end

  always_comb begin
    rd_req  = bus.read & {NUMRDPT{ready_r}};
    wr_req  = bus.write & {NUMWRPT{ready_r}};
    rd_pack = '0;
    coll    = 1'b0;
    err     = 1'b0;
    for (int i = 0; i < NUMRDPT; i++) begin
      rd_a[i] = bus.rd_adr[i*BITADDR +: BITADDR];
      if (rd_req[i]) begin
        if (in_range(rd_a[i])) rd_pack[i*BITDATA +: BITDATA] = mem[rd_a[i]];
        else                   err = 1'b1;
      end
    end
    for (int j = 0; j < NUMWRPT; j++) begin
      wr_a[j] = bus.wr_adr[j*BITADDR +: BITADDR];
      if (wr_req[j] && !in_range(wr_a[j])) err = 1'b1;
    end
    for (int j = 0; j < NUMWRPT; j++) begin
      for (int k = j + 1; k < NUMWRPT; k++) begin
        if (wr_req[j] && wr_req[k] && (wr_a[j] == wr_a[k])) coll = 1'b1;
      end
    end
  end

  // Ascending port order makes the highest-indexed writer win a conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (walk_en) mem[cnt] <= init_val;
      for (int j = 0; j < NUMWRPT; j++) begin
        if (wr_req[j] && in_range(wr_a[j]))
          mem[wr_a[j]] <= bus.wr_din[j*BITDATA +: BITDATA];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SRAM_DELAY; k++) begin
        pipe_vld[k] <= '0;
        pipe_dat[k] <= '0;
      end
      coll_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      pipe_vld[0] <= rd_req;
      pipe_dat[0] <= rd_pack;
      for (int k = 1; k < SRAM_DELAY; k++) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_dat[k] <= pipe_dat[k-1];
      end
      coll_r <= coll;
      err_r  <= err;
    end
  end

  assign bus.ready   = ready_r;
  assign bus.rd_vld  = pipe_vld[SRAM_DELAY-1];
  assign bus.rd_dout = pipe_dat[SRAM_DELAY-1];
  assign bus.wr_coll = coll_r;
  assign bus.adr_err = err_r;

endmodule

// File: doc/atom_nrnw.md
Name: atom_nrnw

Overview:
Parametrised multiport memory atom with NUMRDPT read ports and NUMWRPT write ports, synthesizable for simulation and formal use. It adds the following:
- registered read latency with per-port valid
- a sequenced reset-initialisation walk gating `ready`
- deterministic write-collision priority with a collision flag
- out-of-range address handling

It sits under the multiport memory wrappers as the leaf storage model.

Parameters:
NUMADDR, 8, number of words (need not be a power of two)
BITADDR, 3, address width; must satisfy 2^BITADDR >= NUMADDR
BITDATA, 8, word width
NUMRDPT, 2, number of read ports (>=1)
NUMWRPT, 2, number of write ports (>=1)
SRAM_DELAY, 1, read latency in cycles (>=1)
RSTINIT, 0, 1 = walk-initialise memory after reset; 0 = skip the walk, contents undefined
RSTSTRT, 0, init value of word 0
RSTINCR, 0, init increment per address; word i = RSTSTRT + i*RSTINCR, truncated to BITDATA

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
ready  output  1  high when the memory accepts reads and writes
read  input  NUMRDPT  per-port read request
rd_adr  input  NUMRDPT*BITADDR  read addresses; port i occupies bits [i*BITADDR +: BITADDR]
rd_vld  output  NUMRDPT  read data valid, per port
rd_dout  output  NUMRDPT*BITDATA  read data; port i occupies [i*BITDATA +: BITDATA]
write  input  NUMWRPT  per-port write request
wr_adr  input  NUMWRPT*BITADDR  write addresses, packed like rd_adr
wr_din  input  NUMWRPT*BITDATA  write data, packed like rd_dout
wr_coll  output  1  registered pulse: two or more write ports targeted one address in the same cycle
adr_err  output  1  registered pulse: any accepted request used an address >= NUMADDR

Behaviour:
- One clock `clk`. Reset `rst` is synchronous and active-high.
- FSM states are INIT and READY.
  - Any edge with rst=1 sets: state=INIT, init counter cnt=0, ready=0, all rd_vld=0, rd_dout=0, wr_coll=0, adr_err=0, and flushes the read pipeline.
  - Memory contents are not cleared by rst itself.
- INIT with RSTINIT=0: the first edge with rst=0 moves the FSM to READY, so ready=1 after that edge.
- INIT with RSTINIT=1:
  - At each edge with rst=0, write mem[cnt] = RSTSTRT + cnt*RSTINCR and increment cnt.
  - At the edge where cnt==NUMADDR-1, move to READY.
  - ready rises after the NUMADDR-th non-reset edge.
- ready is a registered copy of state==READY.
- Requests are ignored (no write, no rd_vld) while ready=0.
- rst asserted mid-INIT or mid-operation aborts the walk, drops in-flight reads (rd_vld=0 next cycle) and restarts INIT.
- Writes (ready=1):
  - Port j with write[j]=1 and wr_adr<NUMADDR updates the word at the edge.
  - Same-address conflict: the highest-indexed write port wins; wr_coll=1 for exactly the following cycle.
  - Writes to different addresses on the same cycle all complete.
- Reads (ready=1):
  - read[i] samples the array at the request edge with read-before-write semantics, i.e. the pre-write value is returned for a same-cycle write to that address.
  - rd_vld[i]=1 and rd_dout[i] are presented exactly SRAM_DELAY cycles after the request cycle.
  - Pipelined back-to-back reads are supported every cycle on every port.
  - Multiple ports reading the same address all return the same word.
  - rd_dout[i]=0 whenever rd_vld[i]=0.
- Out-of-range addresses (>= NUMADDR):
  - A write is dropped.
  - A read returns rd_vld=1 with rd_dout=0.
  - adr_err=1 for the following cycle.
- rd_vld, rd_dout, wr_coll and adr_err are all registered; there are no combinational input-to-output paths.

Test Plan:
- Init walk (defaults with RSTINIT=1, RSTSTRT=5, RSTINCR=3): 2 cycles rst=1, then rst=0 → ready=0 for the first 7 non-reset edges and 1 after the 8th. Reading addresses 0..7 returns 5,8,11,14,17,20,23,26 one cycle later with rd_vld=1.
- Read latency (SRAM_DELAY=3):
  - Write 0xA5 to address 2, then read port 1 at address 2 on cycle T → rd_vld[1]=1 and rd_dout[1]=0xA5 at T+3 only.
  - Reads on cycles T, T+1, T+2 return in consecutive cycles.
- Collision: port0 writes 0x11 and port1 writes 0x22 to address 4 on the same cycle → wr_coll=1 on the next cycle; a later read of address 4 returns 0x22.
- Read-before-write: address 3 holds 0x40; on the same cycle, write 0x41 and read address 3 → read returns 0x40; the next read returns 0x41.
- Out-of-range (NUMADDR=6): write 0x99 to address 7 and read address 7 → adr_err=1 next cycle; read gives rd_vld=1, rd_dout=0; addresses 0..5 are unchanged.
- Mid-operation reset (RSTINIT=1): assert rst for 1 cycle during walk step 4 and with a read in flight → rd_vld stays 0, ready=0, and the walk restarts at address 0, taking the full 8 edges before ready=1.
